// File: rtl/mc_datapath.sv
// mc_datapath: multicycle datapath and control for a small ARM-like core.
// Instruction fetch and data access share one memory port with a req/ready handshake.
// Optional feature macro: MC_DATAPATH_MUL_EN. When it is defined, the encoding
// op=00, cmd=0000, I=0, instr[7:4]=1001 executes MUL. Otherwise that encoding runs as AND.
module mc_datapath #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [3:0]  flags,
    output logic        fault,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        FAULT  = 4'd10
    } state_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    state_t      state_reg, state_next;
    logic        active_reg;
    logic [31:0] pc_reg;
    logic [3:0]  flags_reg;
    logic [31:0] wait_cnt_reg;
    logic [31:0] ir_reg;
    logic [31:0] addr_reg;
    logic [31:0] data_reg;
    logic [31:0] res_reg;
    logic        c_reg, v_reg;

    // Instruction fields
    logic [3:0]  cond, cmd, rn, rd, rs, rm;
    logic [1:0]  op;
    logic        imm_bit, s_bit, u_bit, l_bit;
    logic [7:0]  imm8;
    logic [11:0] imm12;
    logic [23:0] imm24;

    assign cond    = ir_reg[31:28];
    assign op      = ir_reg[27:26];
    assign imm_bit = ir_reg[25];
    assign cmd     = ir_reg[24:21];
    assign s_bit   = ir_reg[20];
    assign l_bit   = ir_reg[20];
    assign u_bit   = ir_reg[23];
    assign rn      = ir_reg[19:16];
    assign rd      = ir_reg[15:12];
    assign rs      = ir_reg[11:8];
    assign rm      = ir_reg[3:0];
    assign imm8    = ir_reg[7:0];
    assign imm12   = ir_reg[11:0];
    assign imm24   = ir_reg[23:0];

    logic is_mul;
    logic is_cmp;
`ifdef MC_DATAPATH_MUL_EN
    assign is_mul = (op == 2'b00) && !imm_bit && (cmd == CMD_AND) && (ir_reg[7:4] == 4'b1001);
`else
    assign is_mul = 1'b0;
`endif
    assign is_cmp = (cmd == CMD_CMP);

    // Register file: 16x32, two registered read ports, one write port
    logic [31:0] rf [0:15];
    logic [3:0]  ra_addr, rb_addr;
    logic [31:0] ra_raw_reg, rb_raw_reg;
    logic        ra_pc_reg, rb_pc_reg;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] a_val, b_val;

    // Port A carries Rn (Rs for MUL); port B carries Rd for stores, Rm otherwise
    assign ra_addr = is_mul ? rs : rn;
    assign rb_addr = (op == 2'b01) ? rd : rm;

    // Register file write and operand read, captured while in DECODE
    always_ff @(posedge clk) begin
        if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
        if (state_reg == DECODE) begin
            ra_raw_reg <= rf[ra_addr];
            rb_raw_reg <= rf[rb_addr];
            ra_pc_reg  <= (ra_addr == 4'd15);
            rb_pc_reg  <= (rb_addr == 4'd15);
        end
    end

    // pc has already moved past the instruction, so instruction address + 8 is pc + 4
    assign a_val = ra_pc_reg ? (pc_reg + 32'd4) : ra_raw_reg;
    assign b_val = rb_pc_reg ? (pc_reg + 32'd4) : rb_raw_reg;

    // ALU
    logic [31:0] b_op;
    logic [32:0] add_sum, sub_diff;
    logic [31:0] alu_res;
    logic        alu_c, alu_v;
    logic [31:0] mul_res;

    assign b_op     = (state_reg == EXECI) ? {24'd0, imm8} : b_val;
    assign add_sum  = {1'b0, a_val} + {1'b0, b_op};
    assign sub_diff = {1'b0, a_val} + {1'b0, ~b_op} + 33'd1;
    assign mul_res  = a_val * b_val;

    // Result and adder carry/overflow for the current data-processing command
    always_comb begin
        alu_res = 32'd0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        if (is_mul) begin
            alu_res = mul_res;
        end else begin
            case (cmd)
                CMD_ADD: begin
                    alu_res = add_sum[31:0];
                    alu_c   = add_sum[32];
                    alu_v   = (a_val[31] == b_op[31]) && (add_sum[31] != a_val[31]);
                end
                CMD_SUB, CMD_CMP: begin
                    alu_res = sub_diff[31:0];
                    alu_c   = sub_diff[32];
                    alu_v   = (a_val[31] != b_op[31]) && (sub_diff[31] != a_val[31]);
                end
                CMD_AND: alu_res = a_val & b_op;
                CMD_ORR: alu_res = a_val | b_op;
                default: alu_res = 32'd0;
            endcase
        end
    end

    // Condition evaluation against NZCV
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    cond_ok = z;
            4'h1:    cond_ok = !z;
            4'h2:    cond_ok = cy;
            4'h3:    cond_ok = !cy;
            4'h4:    cond_ok = n;
            4'h5:    cond_ok = !n;
            4'h6:    cond_ok = v;
            4'h7:    cond_ok = !v;
            4'h8:    cond_ok = cy && !z;
            4'h9:    cond_ok = !cy || z;
            4'hA:    cond_ok = (n == v);
            4'hB:    cond_ok = (n != v);
            4'hC:    cond_ok = !z && (n == v);
            4'hD:    cond_ok = z || (n != v);
            default: cond_ok = 1'b1;
        endcase
    endfunction

    logic cmd_valid;
    logic mem_done;
    logic timeout_hit;

    assign cmd_valid = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
                       (cmd == CMD_ORR) || (cmd == CMD_CMP);
    assign mem_done    = mem_req && mem_ready;
    assign timeout_hit = (BUS_TIMEOUT != 0) && mem_req && !mem_ready &&
                         (wait_cnt_reg == BUS_TIMEOUT - 1);

    // State register; active_reg holds off the first request until reset has been low for an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= FETCH;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            active_reg <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH: begin
                if (timeout_hit)   state_next = FAULT;
                else if (mem_done) state_next = DECODE;
            end
            DECODE: begin
                if (cond == 4'hF)                 state_next = FAULT;
                else if (!cond_ok(cond, flags_reg)) state_next = FETCH;
                else begin
                    case (op)
                        2'b01:   state_next = MEMADR;
                        2'b10:   state_next = BRANCH;
                        2'b00: begin
                            if (!cmd_valid)   state_next = FAULT;
                            else if (imm_bit) state_next = EXECI;
                            else              state_next = EXECR;
                        end
                        default: state_next = FAULT;
                    endcase
                end
            end
            MEMADR: state_next = l_bit ? MEMRD : MEMWR;
            MEMRD: begin
                if (timeout_hit)   state_next = FAULT;
                else if (mem_done) state_next = MEMWB;
            end
            MEMWB: state_next = FETCH;
            MEMWR: begin
                if (timeout_hit)   state_next = FAULT;
                else if (mem_done) state_next = FETCH;
            end
            EXECR, EXECI: state_next = ALUWB;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            FAULT:  state_next = FAULT;
            default: state_next = FAULT;
        endcase
    end

    // Bus and status outputs
    always_comb begin
        mem_req   = active_reg && ((state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR));
        mem_we    = (state_reg == MEMWR);
        mem_addr  = (state_reg == FETCH) ? pc_reg : addr_reg;
        mem_wdata = b_val;
        pc        = pc_reg;
        flags     = flags_reg;
        fault     = (state_reg == FAULT);
        state     = state_reg;
    end

    // Register-file write requests; a write to R15 is redirected to pc instead
    always_comb begin
        rf_waddr = rd;
        rf_wdata = (state_reg == MEMWB) ? data_reg : res_reg;
        rf_we    = !reset && (rd != 4'd15) &&
                   (((state_reg == ALUWB) && !is_cmp) || (state_reg == MEMWB));
    end

    // Datapath registers: pc, flags, wait counter, instruction and intermediate values
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            flags_reg    <= 4'd0;
            wait_cnt_reg <= 32'd0;
        end else begin
            if (mem_done) begin
                wait_cnt_reg <= 32'd0;
            end else if (mem_req) begin
                wait_cnt_reg <= wait_cnt_reg + 32'd1;
            end
            case (state_reg)
                FETCH: begin
                    if (mem_done) begin
                        ir_reg <= mem_rdata;
                        pc_reg <= pc_reg + 32'd4;
                    end
                end
                MEMADR: begin
                    addr_reg <= u_bit ? (a_val + {20'd0, imm12}) : (a_val - {20'd0, imm12});
                end
                MEMRD: begin
                    if (mem_done) data_reg <= mem_rdata;
                end
                MEMWB: begin
                    if (rd == 4'd15) pc_reg <= data_reg;
                end
                EXECR, EXECI: begin
                    res_reg <= alu_res;
                    c_reg   <= alu_c;
                    v_reg   <= alu_v;
                end
                ALUWB: begin
                    if (!is_cmp && (rd == 4'd15)) pc_reg <= res_reg;
                    if (s_bit || is_cmp) begin
                        flags_reg[3] <= res_reg[31];
                        flags_reg[2] <= (res_reg == 32'd0);
                        if (!is_mul) begin
                            flags_reg[1] <= c_reg;
                            flags_reg[0] <= v_reg;
                        end
                    end
                end
                BRANCH: begin
                    pc_reg <= pc_reg + 32'd4 + {{6{imm24[23]}}, imm24, 2'b00};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed program run against a word-addressed memory model,
// followed by fault recovery and bus-timeout checks.
module tb_mc_datapath;

    logic        clk;
    logic        reset;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic [31:0] pc;
    logic [3:0]  flags;
    logic        fault;
    logic [3:0]  state;

    mc_datapath #(
        .RESET_PC   (32'h0000_0100),
        .BUS_TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .pc       (pc),
        .flags    (flags),
        .fault    (fault),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    logic [31:0] mem [0:255];
    logic        ready_en;
    logic [31:0] stall_addr;
    int          stall_cnt;
    int          hold_cnt;
    int          we_cycles;
    int          wait_cycles;
    logic        pend_pc;

    logic [31:0] fetch_q[$];
    int          fetch_cyc_q[$];
    logic [3:0]  flag_q[$];
    logic [31:0] pc_after_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive inputs at the falling edge, log any handshake, advance a clock
    task automatic drive_cycle();
        mem_rdata = mem[mem_addr[9:2]];
        mem_ready = ready_en;
        if (mem_req && (mem_addr == stall_addr) && (stall_cnt > 0)) begin
            mem_ready = 1'b0;
            stall_cnt--;
        end
        if (mem_req && mem_we && (mem_addr == stall_addr)) hold_cnt++;
        if (mem_req && mem_we) we_cycles++;
        if (mem_req && !mem_ready) wait_cycles++;
        if (pend_pc) begin
            pc_after_q.push_back(pc);
            pend_pc = 1'b0;
        end
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                mem[mem_addr[9:2]] = mem_wdata;
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
                $display("cycle %0d write addr=%h data=%h", cycle, mem_addr, mem_wdata);
            end else if (state == 4'd0) begin
                fetch_q.push_back(mem_addr);
                fetch_cyc_q.push_back(cycle);
                flag_q.push_back(flags);
                pend_pc = 1'b1;
                $display("cycle %0d fetch addr=%h instr=%h flags=%h", cycle, mem_addr, mem_rdata, flags);
            end else begin
                $display("cycle %0d read addr=%h data=%h", cycle, mem_addr, mem_rdata);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    logic [31:0] exp_fetch [0:13];
    logic [31:0] got;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h00] = 32'h0000_0040;   // data for LDR PC,[R0]
        mem[8'h10] = 32'hE020_0000;   // 0x040: undefined cmd 0001 -> FAULT
        mem[8'h20] = 32'h0000_0200;   // data for R3
        mem[8'h21] = 32'h0000_DEAD;   // data for R2
        mem[8'h40] = 32'hE200_0000;   // 0x100: AND  R0,R0,#0
        mem[8'h41] = 32'hE590_3080;   // 0x104: LDR  R3,[R0,#0x80]
        mem[8'h42] = 32'hE590_2084;   // 0x108: LDR  R2,[R0,#0x84]
        mem[8'h43] = 32'hE280_0003;   // 0x10C: ADD  R0,R0,#3
        mem[8'h44] = 32'hE280_1005;   // 0x110: ADD  R1,R0,#5
        mem[8'h45] = 32'hE583_1008;   // 0x114: STR  R1,[R3,#8]
        mem[8'h46] = 32'hE583_2004;   // 0x118: STR  R2,[R3,#4]
        mem[8'h47] = 32'hE250_0002;   // 0x11C: SUBS R0,R0,#2
        mem[8'h48] = 32'hE250_0001;   // 0x120: SUBS R0,R0,#1
        mem[8'h49] = 32'h1A00_0004;   // 0x124: BNE  (not taken)
        mem[8'h4A] = 32'h1583_2004;   // 0x128: STRNE (skipped)
        mem[8'h4B] = 32'h0A00_0001;   // 0x12C: BEQ  -> 0x138
        mem[8'h4C] = 32'hFFFF_FFFF;   // 0x130: must not run
        mem[8'h4D] = 32'hFFFF_FFFF;   // 0x134: must not run
        mem[8'h4E] = 32'hE590_F000;   // 0x138: LDR  PC,[R0]

        exp_fetch = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118,
                      32'h11C, 32'h120, 32'h124, 32'h128, 32'h12C, 32'h138, 32'h040};

        ready_en   = 1'b1;
        stall_addr = 32'h0000_0204;
        stall_cnt  = 3;
        hold_cnt   = 0;
        we_cycles  = 0;
        pend_pc    = 1'b0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'd0;
        reset      = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_pc", pc, 32'h100);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);

        reset = 1'b0;
        @(negedge clk);
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", mem_addr, 32'h100);
        check("first_we", 32'(mem_we), 32'd0);

        for (int i = 0; i < 300 && !fault; i++) drive_cycle();

        check("fetch_count", 32'(fetch_q.size()), 32'd14);
        for (int i = 0; i < 14; i++) begin
            got = (fetch_q.size() > i) ? fetch_q[i] : 32'hDEAD_BEEF;
            check($sformatf("fetch%0d", i), got, exp_fetch[i]);
        end
        if (fetch_cyc_q.size() > 5)
            check("add_latency", 32'(fetch_cyc_q[5] - fetch_cyc_q[4]), 32'd4);
        else
            check("add_latency", 32'd0, 32'd4);
        got = (pc_after_q.size() > 4) ? pc_after_q[4] : 32'hDEAD_BEEF;
        check("add_pc", got, 32'h114);

        check("wr_count", 32'(wr_addr_q.size()), 32'd2);
        got = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hDEAD_BEEF;
        check("wr0_addr", got, 32'h208);
        got = (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hDEAD_BEEF;
        check("wr0_data_r1", got, 32'h8);
        got = (wr_addr_q.size() > 1) ? wr_addr_q[1] : 32'hDEAD_BEEF;
        check("wr1_addr", got, 32'h204);
        got = (wr_data_q.size() > 1) ? wr_data_q[1] : 32'hDEAD_BEEF;
        check("wr1_data", got, 32'hDEAD);
        check("str_hold", 32'(hold_cnt), 32'd4);
        check("we_cycles", 32'(we_cycles), 32'd5);

        got = (flag_q.size() > 8) ? 32'(flag_q[8]) : 32'hDEAD_BEEF;
        check("flags_subs2", got, 32'h2);
        got = (flag_q.size() > 9) ? 32'(flag_q[9]) : 32'hDEAD_BEEF;
        check("flags_subs1", got, 32'h6);
        got = (flag_q.size() > 12) ? 32'(flag_q[12]) : 32'hDEAD_BEEF;
        check("flags_held", got, 32'h6);

        check("undef_fault", 32'(fault), 32'd1);
        check("undef_state", 32'(state), 32'd10);
        check("undef_req", 32'(mem_req), 32'd0);

        // Reset must clear the fault
        reset = 1'b1;
        @(negedge clk);
        check("rst2_fault", 32'(fault), 32'd0);
        check("rst2_pc", pc, 32'h100);
        check("rst2_req", 32'(mem_req), 32'd0);
        check("rst2_flags", 32'(flags), 32'd0);

        // Bus timeout: memory never answers
        reset       = 1'b0;
        ready_en    = 1'b0;
        wait_cycles = 0;
        @(negedge clk);
        check("to_req", 32'(mem_req), 32'd1);
        for (int i = 0; i < 20 && !fault; i++) drive_cycle();
        $display("timeout reached after %0d wait cycles", wait_cycles);
        check("to_waits", 32'(wait_cycles), 32'd8);
        check("to_fault", 32'(fault), 32'd1);
        check("to_req_low", 32'(mem_req), 32'd0);

        reset = 1'b1;
        @(negedge clk);
        check("rst3_fault", 32'(fault), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
